// File: rtl/iob_wstrb_split.sv
// iob_wstrb_split: splits one strobed write into naturally-aligned,
// contiguous power-of-two sub-word beats, emitted in ascending lane order.
// Optional feature macro: IOB_WSTRB_SPLIT_MERGE_EN
//   defined   -> each beat is the largest aligned power-of-two run of lanes
//   undefined -> each set lane is emitted as its own byte beat
module iob_wstrb_split #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W/8-1:0] in_wstrb,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  output logic                out_last
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LW = $clog2(NB);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state, w_state_nx;
  logic [NB-1:0]       r_rem, w_rem_nx;
  logic [ADDR_W-1:0]   r_base, w_base_nx;
  logic [NB-1:0]       w_src, w_beat;
  logic [LW-1:0]       w_off;
  logic                w_hs, w_acc;
  logic                w_ready_nx, w_valid_nx, w_last_nx;
  logic [ADDR_W-1:0]   w_addr_nx, w_in_base;
  logic [DATA_W-1:0]   w_wdata_nx;
  logic [NB-1:0]       w_wstrb_nx;

  // Lane index of the lowest set strobe bit (0 for an empty mask).
  function automatic logic [LW-1:0] f_low(input logic [NB-1:0] mask);
    logic [LW-1:0] idx;
    logic          found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (mask[i] && !found) begin
        idx   = LW'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Strobe of the beat that starts at the lowest set lane of mask.
  function automatic logic [NB-1:0] f_chunk(input logic [NB-1:0] mask);
    logic [NB-1:0] res;
    int unsigned   p;
    logic          found;
`ifdef IOB_WSTRB_SPLIT_MERGE_EN
    logic [NB-1:0] cand;
    int unsigned   s;
`endif
    res   = '0;
    p     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (mask[i] && !found) begin
        p     = i;
        found = 1'b1;
      end
    end
`ifdef IOB_WSTRB_SPLIT_MERGE_EN
    // Valid sizes are nested (s valid implies s/2 valid), so the last hit
    // in ascending order is the largest legal chunk.
    for (int unsigned k = 0; k <= LW; k++) begin
      s    = 32'd1 << k;
      cand = '0;
      for (int unsigned i = 0; i < NB; i++) begin
        cand[i] = (i >= p) && (i < p + s);
      end
      if ((p % s == 0) && ((mask & cand) == cand)) begin
        res = cand;
      end
    end
`else
    for (int unsigned i = 0; i < NB; i++) begin
      res[i] = (i == p) && mask[i];
    end
`endif
    return res;
  endfunction

  // Beat source: the incoming strobe when idle, otherwise what is left
  // once the currently presented beat has been taken.
  always_comb begin
    w_hs      = out_valid && out_ready;
    w_acc     = (r_state == IDLE) && in_valid && (|in_wstrb);
    w_src     = (r_state == IDLE) ? in_wstrb : (r_rem & ~out_wstrb);
    w_beat    = f_chunk(w_src);
    w_off     = f_low(w_src);
    w_in_base = in_addr & ~ADDR_W'(NB - 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: if (w_acc) w_state_nx = SEND;
      SEND: if (w_hs && out_last) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and request context.
  always_comb begin
    w_rem_nx   = r_rem;
    w_base_nx  = r_base;
    w_valid_nx = out_valid;
    w_wstrb_nx = out_wstrb;
    w_addr_nx  = out_addr;
    w_wdata_nx = out_wdata;
    w_last_nx  = out_last;
    w_ready_nx = (w_state_nx == IDLE);
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_rem_nx   = in_wstrb;
          w_base_nx  = w_in_base;
          w_wdata_nx = in_wdata;
          w_valid_nx = 1'b1;
          w_wstrb_nx = w_beat;
          w_addr_nx  = w_in_base | ADDR_W'(w_off);
          w_last_nx  = ((w_src & ~w_beat) == '0);
        end
      end
      SEND: begin
        if (w_hs) begin
          if (out_last) begin
            w_rem_nx   = '0;
            w_valid_nx = 1'b0;
            w_wstrb_nx = '0;
            w_last_nx  = 1'b0;
          end else begin
            w_rem_nx   = w_src;
            w_valid_nx = 1'b1;
            w_wstrb_nx = w_beat;
            w_addr_nx  = r_base | ADDR_W'(w_off);
            w_last_nx  = ((w_src & ~w_beat) == '0);
          end
        end
      end
      default: ;
    endcase
  end

  // Output and context registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_base    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_wstrb <= '0;
      out_addr  <= '0;
      out_wdata <= '0;
      out_last  <= 1'b0;
    end else begin
      r_rem     <= w_rem_nx;
      r_base    <= w_base_nx;
      in_ready  <= w_ready_nx;
      out_valid <= w_valid_nx;
      out_wstrb <= w_wstrb_nx;
      out_addr  <= w_addr_nx;
      out_wdata <= w_wdata_nx;
      out_last  <= w_last_nx;
    end
  end

endmodule
